mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared 128-bit memory port.
// One transaction is granted at a time; ready is steered back to its owner only.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t state_r, state_d;
  logic   grant_r, grant_d;
  logic   last_r, last_d;

  logic                  req_i, req_d;
  logic                  g_read, g_write;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  busy;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  // grant_r: 0 = I-cache, 1 = D-cache
  assign g_read  = grant_r ? d_read  : i_read;
  assign g_write = grant_r ? d_write : i_write;
  assign g_addr  = grant_r ? d_addr  : i_addr;
  assign g_wdata = grant_r ? d_wdata : i_wdata;

  assign busy = (state_r == S_BUSY);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r <= S_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_d;
      grant_r <= grant_d;
      last_r  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_r;
    grant_d   = grant_r;
    last_d    = last_r;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_r)
      S_IDLE: begin
        if (req_i | req_d) begin
          state_d = S_BUSY;
          // On a tie the port not served last wins
          grant_d = (req_i & req_d) ? ~last_r : req_d;
        end
      end
      S_BUSY: begin
        mem_write = g_write;
        mem_read  = g_read & ~g_write;
        mem_addr  = g_addr;
        mem_wdata = g_wdata;
        if (mem_ready) begin
          state_d = S_IDLE;
          last_d  = grant_r;
        end else if (!(g_read | g_write)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i_ready = mem_ready & busy & ~grant_r;
  assign d_ready = mem_ready & busy & grant_r;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected grants.
// The bench plays both caches and the memory model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  logic last_m = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.port = port;
    e.wr = wr;
    e.addr = a;
    e.wdata = d;
    q.push_back(e);
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] rd);
    exp_t e;
    int   w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(mem_read | mem_write) && w < 20);
    chk("grant_latency", DW'(w), DW'(2));
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=grant expected=none");
      return;
    end
    e = q.pop_front();
    chk("mem_write", DW'(mem_write), DW'(e.wr));
    chk("mem_read", DW'(mem_read), DW'(!e.wr));
    chk("mem_addr", DW'(mem_addr), DW'(e.addr));
    chk("mem_wdata", mem_wdata, e.wdata);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("hold_req", DW'({mem_read, mem_write}),
          DW'(e.wr ? 2'b01 : 2'b10));
      chk("no_early_ready", DW'({i_ready, d_ready}), DW'(2'b00));
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    chk("i_ready", DW'(i_ready), DW'(!e.port));
    chk("d_ready", DW'(d_ready), DW'(e.port));
    chk("i_rdata", i_rdata, rd);
    chk("d_rdata", d_rdata, rd);
    tick();
    mem_ready = 1'b0;
    if (e.port) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
      i_write = 1'b0;
    end
  endtask

  initial begin
    logic p;
    proc_reset = 1'b1;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0;
    mem_rdata = 128'hDEAD;
    tick();
    tick();
    proc_reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", DW'(mem_read), DW'(0));
    chk("rst_mem_write", DW'(mem_write), DW'(0));
    chk("rst_mem_addr", DW'(mem_addr), DW'(0));
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_ready", DW'({i_ready, d_ready}), DW'(0));
    chk("rst_rdata", i_rdata, 128'hDEAD);
    tick();

    // single I read
    i_addr = 28'h0000010;
    i_read = 1;
    push(0, 0, 28'h0000010, '0);
    serve(4, {16{8'hA5}});
    last_m = 0;

    // simultaneous: D wins since I served last
    i_read = 1; i_addr = 28'h0000020;
    d_write = 1; d_addr = 28'h0000123; d_wdata = 128'h1234;
    push(1, 1, 28'h0000123, 128'h1234);
    push(0, 0, 28'h0000020, '0);
    serve(3, 128'h1);
    d_wdata = '0;
    serve(2, 128'h2);
    last_m = 0;

    // round-robin under continuous contention
    for (int k = 0; k < 6; k++) begin
      if (!i_read) begin
        i_read = 1;
        i_addr = 28'h100 + AW'(k);
      end
      if (!d_read) begin
        d_read = 1;
        d_addr = 28'h200 + AW'(k);
      end
      p = ~last_m;
      push(p, 0, p ? d_addr : i_addr, '0);
      last_m = p;
      serve(2 + (k % 3), DW'(k + 100));
    end
    d_read = 0;

    // write-back then fetch, with I pending in between
    d_write = 1; d_addr = 28'h40; d_wdata = {4{32'hCAFEF00D}};
    i_read = 1; i_addr = 28'h10;
    push(1, 1, 28'h40, {4{32'hCAFEF00D}});
    push(0, 0, 28'h10, '0);
    push(1, 0, 28'h80, '0);
    serve(3, 128'h11);
    d_wdata = '0;
    d_read = 1; d_addr = 28'h80;
    serve(2, 128'h22);
    serve(4, 128'h33);

    // read and write together: write wins
    i_read = 1; i_write = 1; i_addr = 28'h55; i_wdata = 128'h77;
    push(0, 1, 28'h55, 128'h77);
    serve(2, 128'h44);
    i_wdata = '0;

    // reset mid-transaction
    d_read = 1; d_addr = 28'h300;
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant", DW'(mem_read), DW'(1));
    tick();
    proc_reset = 1;
    d_read = 0;
    tick();
    proc_reset = 0;
    @(negedge clk);
    chk("rst_drop_read", DW'(mem_read), DW'(0));
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("rst_no_ready", DW'({i_ready, d_ready}), DW'(0));
    tick();
    mem_ready = 0;

    // spurious ready while idle
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("idle_no_ready", DW'({i_ready, d_ready}), DW'(0));
    chk("idle_no_req", DW'({mem_read, mem_write}), DW'(0));
    tick();
    mem_ready = 0;
    i_read = 1; i_addr = 28'h66;
    push(0, 0, 28'h66, '0);
    serve(2, 128'h55);

    chk("sb_drain", DW'(q.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
